// File: rtl/dmem_pkg.sv
// Shared types for the MEM-stage data memory: access sizes and controller states.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: size/alignment checks, store merge into the
// addressed word, and load extraction with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int OFF_W  = 3
) (
  input  size_e             size_i,
  input  logic              uns_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rword_i,
  output logic [DATA_W-1:0] wword_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              bad_size_o,
  output logic              misalign_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int SH_W  = $clog2(DATA_W);

  int                off;
  int                nbytes;
  int                nbits;
  logic [BYTES-1:0]  be;
  logic [DATA_W-1:0] wsh;
  logic [DATA_W-1:0] rsh;
  logic [SH_W-1:0]   sidx;
  logic              sbit;

  always_comb begin
    be         = '0;
    wword_o    = rword_i;
    rdata_o    = '0;
    off        = int'(off_i);
    nbytes     = 1 << size_i;
    nbits      = nbytes * 8;
    bad_size_o = nbits > DATA_W;
    misalign_o = (off % nbytes) != 0;
    wsh        = wdata_i << {off_i, 3'b000};
    rsh        = rword_i >> {off_i, 3'b000};
    for (int b = 0; b < BYTES; b++) begin
      be[b]             = (b >= off) && (b < off + nbytes);
      wword_o[8*b +: 8] = be[b] ? wsh[8*b +: 8] : rword_i[8*b +: 8];
    end
    // Clamp the sign-bit index so an illegal size never selects past the word.
    sidx = bad_size_o ? SH_W'(DATA_W - 1) : SH_W'(nbits - 1);
    sbit = !uns_i && rsh[sidx];
    for (int i = 0; i < DATA_W; i++) begin
      rdata_o[i] = (i < nbits) ? rsh[i] : sbit;
    end
    if (bad_size_o) rdata_o = '0;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable little-endian data memory with configurable response
// latency and a self-clearing INIT phase after reset.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 64,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              init_done
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam int IX_W  = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [IX_W-1:0]   ptr_q;
  logic              init_done_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              wr_q;
  size_e             size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              use_in;
  logic              e_wr;
  size_e             e_size;
  logic              e_uns;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  logic [IDX_W-1:0]  idx;
  logic              oor;
  logic              bad_size;
  logic              misalign;
  logic              err;
  logic              fire;
  logic [DATA_W-1:0] rword;
  logic [DATA_W-1:0] wword;
  logic [DATA_W-1:0] rdata_ext;

  // With LATENCY=1 the accept edge is also the RESP-entry edge, so the live
  // request fields stand in for the latched ones on that edge.
  assign use_in  = (state_q == IDLE);
  assign e_wr    = use_in ? req_write          : wr_q;
  assign e_size  = use_in ? size_e'(req_size)  : size_q;
  assign e_uns   = use_in ? req_unsigned       : uns_q;
  assign e_addr  = use_in ? req_addr           : addr_q;
  assign e_wdata = use_in ? req_wdata          : wdata_q;

  assign idx   = e_addr[ADDR_W-1:OFF_W];
  assign oor   = idx >= IDX_W'(DEPTH);
  assign rword = mem_q[idx[IX_W-1:0]];
  assign err   = bad_size || misalign || oor;
  assign fire  = (state_d == RESP) && (state_q != RESP) && !rst;

  dmem_lane_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .size_i     (e_size),
    .uns_i      (e_uns),
    .off_i      (e_addr[OFF_W-1:0]),
    .wdata_i    (e_wdata),
    .rword_i    (rword),
    .wword_o    (wword),
    .rdata_o    (rdata_ext),
    .bad_size_o (bad_size),
    .misalign_o (misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) begin
        ptr_q <= ptr_q + 1'b1;
        if (ptr_q == IX_W'(DEPTH - 1)) init_done_q <= 1'b1;
      end
      if (state_q == IDLE && req_valid) cnt_q <= CNT_W'(LATENCY - 1);
      else if (state_q == WAIT)         cnt_q <= cnt_q - 1'b1;
      if (fire) begin
        err_q   <= err;
        rdata_q <= (err || e_wr) ? '0 : rdata_ext;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (ptr_q == IX_W'(DEPTH - 1)) state_d = IDLE;
      IDLE:    if (req_valid) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_q == CNT_W'(1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    init_done  = init_done_q;
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      wr_q    <= req_write;
      size_q  <= size_e'(req_size);
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Storage carries no reset; INIT sweeps it and stores only commit on RESP entry.
  always_ff @(posedge clk) begin
    if (state_q == INIT)             mem_q[ptr_q]         <= '0;
    else if (fire && e_wr && !err)   mem_q[idx[IX_W-1:0]] <= wword;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: instance A runs LATENCY=1, instance B runs LATENCY=3.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_a, rst_b;
  logic        a_valid, a_ready, a_write, a_uns, a_rvalid, a_err, a_done;
  logic [1:0]  a_size;
  logic [63:0] a_addr, a_wdata, a_rdata;
  logic        b_valid, b_ready, b_write, b_uns, b_rvalid, b_err, b_done;
  logic [1:0]  b_size;
  logic [63:0] b_addr, b_wdata, b_rdata;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  data_mem_ctrl #(.DATA_W(64), .DEPTH(8), .ADDR_W(64), .LATENCY(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(a_write), .req_size(a_size), .req_unsigned(a_uns),
    .req_addr(a_addr), .req_wdata(a_wdata), .resp_valid(a_rvalid),
    .resp_rdata(a_rdata), .resp_err(a_err), .init_done(a_done)
  );

  data_mem_ctrl #(.DATA_W(64), .DEPTH(8), .ADDR_W(64), .LATENCY(3)) u_dut_b (
    .clk(clk), .rst(rst_b), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .req_size(b_size), .req_unsigned(b_uns),
    .req_addr(b_addr), .req_wdata(b_wdata), .resp_valid(b_rvalid),
    .resp_rdata(b_rdata), .resp_err(b_err), .init_done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Issue one request on A and return the response and its latency in cycles.
  task automatic req_a(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       output logic [63:0] rdata, output logic err, output int lat);
    int k;
    k = 0;
    @(negedge clk);
    a_valid = 1'b1; a_write = wr; a_size = sz; a_uns = uns; a_addr = addr; a_wdata = wdata;
    while (!a_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 a_valid = 1'b0;
    lat = 99; rdata = 'x; err = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (a_rvalid) begin
        lat = i; rdata = a_rdata; err = a_err;
        break;
      end
    end
  endtask

  task automatic do_a(input string tag, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [63:0] exp_rdata, input logic exp_err);
    logic [63:0] rd;
    logic        er;
    int          lat;
    req_a(wr, sz, uns, addr, wdata, rd, er, lat);
    chk({tag, "_rdata"}, rd, exp_rdata);
    chk({tag, "_err"}, {63'b0, er}, {63'b0, exp_err});
    chk({tag, "_lat"}, 64'(lat), 64'd1);
  endtask

  // Issue one request on B, checking the ready/valid pattern cycle by cycle.
  task automatic do_b(input string tag, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [63:0] exp_rdata);
    int k;
    k = 0;
    @(negedge clk);
    b_valid = 1'b1; b_write = wr; b_size = sz; b_uns = uns; b_addr = addr; b_wdata = wdata;
    while (!b_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 b_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("%s_ready_c%0d", tag, i), {63'b0, b_ready}, {63'b0, (i == 4)});
      chk($sformatf("%s_rvalid_c%0d", tag, i), {63'b0, b_rvalid}, {63'b0, (i == 3)});
      if (i == 3) chk({tag, "_rdata"}, b_rdata, exp_rdata);
    end
  endtask

  initial begin
    int          k;
    logic        seen;
    rst_a = 1'b1; rst_b = 1'b1;
    a_valid = 1'b0; a_write = 1'b0; a_size = 2'd0; a_uns = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_size = 2'd0; b_uns = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  {63'b0, a_ready},  64'd0);
    chk("rst_rvalid", {63'b0, a_rvalid}, 64'd0);
    chk("rst_rdata",  a_rdata,           64'd0);
    chk("rst_err",    {63'b0, a_err},    64'd0);
    chk("rst_done",   {63'b0, a_done},   64'd0);
    chk("rst_done_b", {63'b0, b_done},   64'd0);

    rst_a = 1'b0; rst_b = 1'b0;
    k = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 7) chk("init_ready_low", {63'b0, a_ready}, 64'd0);
      if (a_done) begin
        k = i;
        break;
      end
    end
    chk("init_cycles", 64'(k), 64'd8);
    chk("init_ready",  {63'b0, a_ready}, 64'd1);
    chk("init_done_b", {63'b0, b_done},  64'd1);

    do_a("ld_d_38",  1'b0, 2'd3, 1'b0, 64'h38, 64'h0, 64'h0, 1'b0);
    do_a("st_d_08",  1'b1, 2'd3, 1'b0, 64'h08, 64'h8877665544332211, 64'h0, 1'b0);
    do_a("ld_b_0f",  1'b0, 2'd0, 1'b0, 64'h0F, 64'h0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0);
    do_a("ld_hu_0a", 1'b0, 2'd1, 1'b1, 64'h0A, 64'h0, 64'h0000_0000_0000_4433, 1'b0);
    do_a("ld_h_0e",  1'b0, 2'd1, 1'b0, 64'h0E, 64'h0, 64'hFFFF_FFFF_FFFF_8877, 1'b0);
    do_a("ld_wu_0c", 1'b0, 2'd2, 1'b1, 64'h0C, 64'h0, 64'h0000_0000_8877_6655, 1'b0);
    do_a("ld_w_08",  1'b0, 2'd2, 1'b0, 64'h08, 64'h0, 64'h0000_0000_4433_2211, 1'b0);
    do_a("ld_bu_0d", 1'b0, 2'd0, 1'b1, 64'h0D, 64'h0, 64'h0000_0000_0000_0066, 1'b0);

    do_a("st_b_11",  1'b1, 2'd0, 1'b0, 64'h11, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0, 1'b0);
    do_a("ld_d_10",  1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 64'h0000_0000_0000_AB00, 1'b0);
    repeat (2) @(negedge clk);
    chk("hold_rdata",  a_rdata,           64'h0000_0000_0000_AB00);
    chk("hold_rvalid", {63'b0, a_rvalid}, 64'd0);
    do_a("st_h_16",  1'b1, 2'd1, 1'b0, 64'h16, 64'h1234_5678_9ABC_BEEF, 64'h0, 1'b0);
    do_a("ld_d_10b", 1'b0, 2'd3, 1'b1, 64'h10, 64'h0, 64'hBEEF_0000_0000_AB00, 1'b0);

    do_a("ld_w_06",  1'b0, 2'd2, 1'b0, 64'h06, 64'h0, 64'h0, 1'b1);
    do_a("st_d_40",  1'b1, 2'd3, 1'b0, 64'h40, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b1);
    do_a("st_h_09",  1'b1, 2'd1, 1'b0, 64'h09, 64'h0000_0000_0000_FFFF, 64'h0, 1'b1);
    do_a("ld_d_00",  1'b0, 2'd3, 1'b0, 64'h00, 64'h0, 64'h0, 1'b0);
    do_a("ld_d_08",  1'b0, 2'd3, 1'b0, 64'h08, 64'h0, 64'h8877665544332211, 1'b0);
    do_a("ld_d_big", 1'b0, 2'd3, 1'b0, 64'h8000_0000_0000_0008, 64'h0, 64'h0, 1'b1);

    do_b("b_st_18", 1'b1, 2'd3, 1'b0, 64'h18, 64'h0123_4567_89AB_CDEF, 64'h0);
    do_b("b_ld_18", 1'b0, 2'd3, 1'b0, 64'h18, 64'h0, 64'h0123_4567_89AB_CDEF);
    do_b("b_ld_b1b", 1'b0, 2'd0, 1'b0, 64'h1B, 64'h0, 64'hFFFF_FFFF_FFFF_FF89);

    // Abort a store on B while it is waiting.
    @(negedge clk);
    b_valid = 1'b1; b_write = 1'b1; b_size = 2'd3; b_uns = 1'b0;
    b_addr = 64'h18; b_wdata = 64'h5555_AAAA_5555_AAAA;
    k = 0;
    while (!b_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 b_valid = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen = seen | b_rvalid;
    end
    chk("abort_done_low", {63'b0, b_done}, 64'd0);
    rst_b = 1'b0;
    k = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      seen = seen | b_rvalid;
      if (b_done) begin
        k = i;
        break;
      end
    end
    chk("abort_no_resp", {63'b0, seen}, 64'd0);
    chk("abort_reinit",  64'(k), 64'd8);
    do_b("b_ld_18_clr", 1'b0, 2'd3, 1'b0, 64'h18, 64'h0, 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
